// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: 1-bit-per-cycle shift-add multiply and restoring divide.
// Owns the architectural HI/LO registers and raises the MFHI/MFLO stall interlock.
module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] rsData,
    input  logic [WIDTH-1:0] rtData,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_req,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        DIV   = 2'd2,
        FIXUP = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [4:0]  count;
    logic        op_div;
    logic        neg_q;
    logic        neg_r;
    logic [31:0] op_a;
    logic [63:0] acc;

    logic        valid_func;
    logic        accept;
    logic        in_signed;
    logic        in_div;
    logic        div_zero;
    logic [31:0] abs_rs;
    logic [31:0] abs_rt;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic        div_ok;
    logic [31:0] div_diff;
    logic [31:0] div_rem;
    logic [63:0] prod;

    // Handshake: start is taken on a rising edge only while busy=0 and func is one of the
    // four mult/div codes; there is no ready, so the issuer must watch busy/stall.
    assign valid_func = (func[5:2] == 4'b0110);
    assign accept     = (state == IDLE) && start && valid_func;
    assign in_signed  = ~func[0];
    assign in_div     = func[1];
    assign div_zero   = in_div && (rtData == 32'h0);
    assign abs_rs     = (in_signed && rsData[31]) ? -rsData : rsData;
    assign abs_rt     = (in_signed && rtData[31]) ? -rtData : rtData;

    // acc holds {partial product, multiplier} while multiplying and
    // {partial remainder, dividend/quotient} while dividing.
    assign mul_sum   = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? op_a : 32'h0)};
    assign div_shift = {acc[63:32], acc[31]};
    assign div_ok    = (div_shift >= {1'b0, op_a});
    assign div_diff  = div_shift[31:0] - op_a;
    assign div_rem   = div_ok ? div_diff : div_shift[31:0];
    assign prod      = neg_q ? -acc : acc;

    assign busy      = (state != IDLE);
    assign stall     = rd_req & busy;
    assign dbg_state = state;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (div_zero)    state_next = FIXUP;
                    else if (in_div) state_next = DIV;
                    else             state_next = MUL;
                end
            end
            MUL:     if (count == 5'd0) state_next = FIXUP;
            DIV:     if (count == 5'd0) state_next = FIXUP;
            FIXUP:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count  <= 5'd0;
            op_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            op_a   <= 32'h0;
            acc    <= 64'h0;
            hi     <= 32'h0;
            lo     <= 32'h0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_hi) hi <= wr_data;
                    if (wr_lo) lo <= wr_data;
                    if (accept) begin
                        op_div <= in_div;
                        count  <= 5'd31;
                        op_a   <= abs_rt;
                        // Divide by zero parks the raw dividend as the remainder.
                        if (div_zero) begin
                            acc   <= {rsData, 32'hFFFF_FFFF};
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                        end else begin
                            acc   <= {32'h0, abs_rs};
                            neg_q <= in_signed & (rsData[31] ^ rtData[31]);
                            neg_r <= in_signed & rsData[31];
                        end
                    end
                end
                MUL: begin
                    acc   <= {mul_sum, acc[31:1]};
                    count <= count - 5'd1;
                end
                DIV: begin
                    acc   <= {div_rem, acc[30:0], div_ok};
                    count <= count - 5'd1;
                end
                FIXUP: begin
                    if (op_div) begin
                        hi <= neg_r ? -acc[63:32] : acc[63:32];
                        lo <= neg_q ? -acc[31:0] : acc[31:0];
                    end else begin
                        hi <= prod[63:32];
                        lo <= prod[31:0];
                    end
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed corner ops plus random back-to-back issues,
// with results predicted by 64-bit arithmetic and checked by a done-triggered monitor.
module tb_muldiv_ctrl;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  func;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wr_data;
    logic        rd_req;
    logic        busy;
    logic        done;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  dbg_state;

    muldiv_ctrl #(.WIDTH(32)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .func     (func),
        .rsData   (rsData),
        .rtData   (rtData),
        .wr_hi    (wr_hi),
        .wr_lo    (wr_lo),
        .wr_data  (wr_data),
        .rd_req   (rd_req),
        .busy     (busy),
        .done     (done),
        .stall    (stall),
        .hi       (hi),
        .lo       (lo),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clock = ~clock;

    int          cmp_count  = 0;
    int          fail_count = 0;
    logic [63:0] exp_q[$];
    logic [31:0] model_hi = 32'h0;
    logic [31:0] model_lo = 32'h0;
    bit          mon_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp_count++;
        if (act !== exp) begin
            fail_count++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; returns {hi, lo}.
    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'h0;
        case (f)
            F_MULT:  p = sa * sb;
            F_MULTU: p = {32'h0, a} * {32'h0, b};
            F_DIV: begin
                if (b == 32'h0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'h0) p = {a, 32'hFFFF_FFFF};
                else            p = {a % b, a / b};
            end
        endcase
        return p;
    endfunction

    // scoreboard monitor
    always @(negedge clock) begin
        if (mon_en && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", {63'h0, done}, 64'h0);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("result_hilo", {hi, lo}, e);
                model_hi = e[63:32];
                model_lo = e[31:0];
            end
        end
    end

    // driver: called at a negedge; drives the issue, then times busy/stall/done.
    // disturb: mid-op start and MTHI that must be dropped. wr_same: MTLO together with start.
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input bit hold_rd, input bit disturb, input bit wr_same);
        int busy_cnt, stall_cnt, lat, exp_lat;
        bit seen;
        func    = f;
        rsData  = a;
        rtData  = b;
        start   = 1'b1;
        if (wr_same) begin
            wr_lo   = 1'b1;
            wr_data = 32'h5A5A_0F0F;
        end
        exp_q.push_back(model(f, a, b));
        @(posedge clock);
        #1;
        start = 1'b0;
        wr_lo = 1'b0;
        if (hold_rd) rd_req = 1'b1;
        busy_cnt  = 0;
        stall_cnt = 0;
        lat       = 0;
        seen      = 1'b0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clock);
            if (busy === 1'b1) busy_cnt++;
            if (stall === 1'b1) stall_cnt++;
            if (wr_same && i == 1) check("mtlo_with_start", {32'h0, lo}, {32'h0, 32'h5A5A_0F0F});
            if (done === 1'b1) begin
                seen = 1'b1;
                lat  = i;
                if (hold_rd) check("stall_in_done_cycle", {63'h0, stall}, 64'h0);
            end else if (disturb && i == 5) begin
                start   = 1'b1;
                func    = F_MULTU;
                rsData  = 32'h0000_0005;
                rtData  = 32'h0000_0007;
                wr_hi   = 1'b1;
                wr_data = 32'hAAAA_5555;
            end else if (disturb && i == 6) begin
                start = 1'b0;
                wr_hi = 1'b0;
            end
        end
        rd_req  = 1'b0;
        exp_lat = (f[1] && b == 32'h0) ? 2 : 34;
        check("done_latency", 64'(lat), 64'(exp_lat));
        check("busy_cycles", 64'(busy_cnt), 64'(exp_lat - 1));
        if (hold_rd) check("stall_cycles", 64'(stall_cnt), 64'(exp_lat - 1));
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        func    = 6'h0;
        rsData  = 32'h0;
        rtData  = 32'h0;
        wr_hi   = 1'b0;
        wr_lo   = 1'b0;
        wr_data = 32'h0;
        rd_req  = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset  = 1'b0;
        mon_en = 1'b1;
        check("reset_busy", {63'h0, busy}, 64'h0);
        check("reset_done", {63'h0, done}, 64'h0);
        check("reset_hilo", {hi, lo}, 64'h0);
        check("reset_state", {62'h0, dbg_state}, 64'h0);

        run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        check("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_op(F_MULT, 32'hFFFF_FFFD, 32'h0000_0005, 1'b0, 1'b0, 1'b0);
        check("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op(F_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        check("mult_minmin", {hi, lo}, 64'h4000_0000_0000_0000);
        run_op(F_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
        check("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(F_DIVU, 32'h0000_0007, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
        check("divu_7_2", {hi, lo}, 64'h0000_0001_0000_0003);
        run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        check("div_overflow", {hi, lo}, 64'h0000_0000_8000_0000);
        run_op(F_DIVU, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 1'b0);
        check("divu_zero", {hi, lo}, 64'h1234_5678_FFFF_FFFF);
        run_op(F_MULTU, 32'h0001_0003, 32'h0000_0011, 1'b0, 1'b1, 1'b0);
        check("disturbed_op", {hi, lo}, 64'h0000_0000_0011_0033);
        run_op(F_DIVU, 32'h0000_0064, 32'h0000_0007, 1'b1, 1'b0, 1'b1);

        // MTHI in IDLE loads hi and leaves lo alone
        wr_hi   = 1'b1;
        wr_data = 32'hAAAA_5555;
        @(posedge clock);
        #1 wr_hi = 1'b0;
        @(negedge clock);
        check("mthi_idle", {hi, lo}, {32'hAAAA_5555, model_lo});

        // reset at iteration 10 of a MULT discards the op without a done pulse
        func   = F_MULT;
        rsData = 32'h1234_5678;
        rtData = 32'h8765_4321;
        start  = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (10) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("midop_reset_busy", {63'h0, busy}, 64'h0);
        check("midop_reset_hilo", {hi, lo}, 64'h0);
        model_hi = 32'h0;
        model_lo = 32'h0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) check("no_done_after_reset", {63'h0, done}, 64'h0);
            @(negedge clock);
        end
        run_op(F_MULTU, 32'h3, 32'h4, 1'b0, 1'b0, 1'b0);
        check("multu_3x4", {hi, lo}, 64'h0000_0000_0000_000C);

        // random back-to-back issues; each accept lands in the previous done cycle
        for (int n = 0; n < 30; n++) begin
            logic [5:0] f;
            case ($urandom_range(0, 3))
                0:       f = F_MULT;
                1:       f = F_MULTU;
                2:       f = F_DIV;
                default: f = F_DIVU;
            endcase
            run_op(f, rand_operand(), rand_operand(), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

        @(negedge clock);
        check("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle sequencer for the HI/LO multiply/divide resource next to the execute-stage ALU. It accepts MULT/MULTU/DIV/DIVU issues with operands from the ALU operand path and runs a 1-bit-per-cycle shift-add multiply or restoring divide. It owns the architectural HI/LO registers and raises a stall interlock for MFHI/MFLO reads while an operation is in flight.

## Interface
- WIDTH, 32, operand width; only 32 is supported.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  issue strobe; accepted only when busy=0.
- func  in  6  R-type funct: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011. Other codes with start=1 are ignored.
- rsData  in  32  multiplicand / dividend.
- rtData  in  32  multiplier / divisor.
- wr_hi, wr_lo  in  1  MTHI/MTLO write strobes.
- wr_data  in  32  MTHI/MTLO data.
- rd_req  in  1  execute stage holds MFHI/MFLO.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse; HI/LO were just updated.
- stall  out  1  equals rd_req & busy (combinational).
- hi, lo  out  32  architectural HI/LO.

## Operation
- States: IDLE, MUL, DIV, FIXUP.
- IDLE with start=1 and a valid func (accept edge):
  - Latch the signed flag: MULT and DIV are signed.
  - Latch |rs| and |rt| when signed, else the raw values.
  - Latch neg_q = signed & (rs[31]^rt[31]) and neg_r = signed & rs[31].
  - Load iteration counter = 31.
  - Go to MUL or DIV.
- Divide by zero (DIV/DIVU with rtData==0): skip iteration and go straight to FIXUP. Result: hi=rsData as issued, lo=32'hFFFFFFFF.
- MUL: 64-bit accumulator, shift-add.
  - Each cycle: if multiplier lsb=1, add multiplicand into the upper half with a 33-bit carry; then shift the accumulator right 1.
  - When counter reaches 0 → FIXUP.
- DIV: restoring division with a 33-bit partial remainder.
  - Each cycle: shift in the next dividend bit from the MSB and trial-subtract the divisor. If the result is non-negative, keep it and set the quotient bit to 1.
  - When counter reaches 0 → FIXUP.
- FIXUP (1 cycle):
  - MUL: if neg_q, negate the 64-bit product (two's complement). Write hi=product[63:32], lo=product[31:0].
  - DIV: lo=quotient, negated if neg_q. hi=remainder, negated if neg_r.
  - 0x80000000 / -1 (signed) gives lo=0x80000000, hi=0 with no exception.
  - Pulse done. Go to IDLE.
- MTHI/MTLO:
  - When busy=0, wr_hi/wr_lo load wr_data into hi/lo at the edge.
  - When busy=1, writes are dropped.
  - A write in the same cycle as an accepted start takes effect; the operation result overwrites it later.
- start while busy=1: ignored, with no queuing. The issuer must respect stall/busy.
- Results are bit-exact with 64-bit signed/unsigned product and C-style truncating division (remainder takes the dividend's sign).

## Timing
- Reset (any state, including mid-operation): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0. The in-flight operation is discarded and no done pulse follows.
- Accept at edge k:
  - busy=1 from after edge k through edge k+33.
  - MUL/DIV iterations occupy edges k+1..k+32.
  - FIXUP at edge k+33 updates hi/lo.
  - After k+33: done=1 for one cycle, busy=0, and new hi/lo are visible.
- Throughput: a new start is accepted in the done cycle, so back-to-back issues are 34 cycles apart.
- Divide by zero: FIXUP at edge k+1. busy is high for one cycle and done follows edge k+1.
- stall tracks busy: high for exactly 33 cycles for a normal op, low in the done cycle, so MFHI/MFLO completes with new data.
- hi/lo change only at FIXUP, MTHI/MTLO and reset edges; they never show intermediate values.

## Test plan
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; done exactly 34 cycles after the accept edge; busy high for 33 cycles.
- MULT rs=0xFFFFFFFD (-3), rt=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then MULT 0x80000000 × 0x80000000 → hi=0x40000000, lo=0.
- DIV rs=-7, rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 → lo=3, hi=1. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU rs=0x12345678, rt=0 → busy for 1 cycle, hi=0x12345678, lo=0xFFFFFFFF.
- Interlock:
  - Hold rd_req=1 from the cycle after accept → stall=1 for 33 cycles, 0 in the done cycle.
  - A second start mid-operation is ignored: hi/lo reflect only the first op.
  - wr_hi=1 (0xAAAA5555) mid-operation is dropped; in IDLE it loads hi.
- Assert reset at iteration 10 of a MULT → next cycle busy=0, hi=lo=0, no done. A following MULTU 3×4 gives lo=12, hi=0.
